// File: rtl/cpu_pkg.sv
// Shared register-file constants and FSM state encoding.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH    = 10;
    localparam int unsigned ADDRESS_WIDTH = 3;
    localparam int unsigned DEPTH         = 1 << ADDRESS_WIDTH;

    // CLEAR zeroes the array after reset; READY serves requests until the next reset.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

endpackage : cpu_pkg

// File: rtl/data_regfile.sv
// Two-read / one-write register file with a post-reset clear sequencer.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to
// a read of the same address; otherwise such a read returns the old contents.
module data_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = cpu_pkg::ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     readA,
    input  logic                     readB,
    input  logic [ADDRESS_WIDTH-1:0] addr_opA,
    input  logic [ADDRESS_WIDTH-1:0] addr_opB,
    output logic [DATA_WIDTH-1:0]    data_opA,
    output logic [DATA_WIDTH-1:0]    data_opB,
    output logic                     validA,
    output logic                     validB,
    input  logic                     write_Res,
    input  logic [ADDRESS_WIDTH-1:0] addr_Res,
    input  logic [DATA_WIDTH-1:0]    data_Res,
    output logic                     wr_ack,
    output logic                     ready,
    output logic                     drop_err
);

    localparam int unsigned                DEPTH    = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0]   LAST_PTR = ADDRESS_WIDTH'(DEPTH - 1);

    rf_state_e                  state;
    logic [ADDRESS_WIDTH-1:0]   clr_ptr;
    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [DATA_WIDTH-1:0]      rd_a_c;
    logic [DATA_WIDTH-1:0]      rd_b_c;

    // Read-port muxes, with optional forwarding of the write in flight.
    always_comb begin
        rd_a_c = mem[addr_opA];
        rd_b_c = mem[addr_opB];
`ifdef REGFILE_BYPASS_EN
        if (write_Res && (addr_opA == addr_Res)) begin
            rd_a_c = data_Res;
        end
        if (write_Res && (addr_opB == addr_Res)) begin
            rd_b_c = data_Res;
        end
`endif
    end

    // Array update: zero fill while clearing, committed writes once ready; nothing at a reset edge.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (write_Res) begin
                mem[addr_Res] <= data_Res;
            end
        end
    end

    // Control FSM with registered read data, pulses and status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            data_opA <= '0;
            data_opB <= '0;
            validA   <= 1'b0;
            validB   <= 1'b0;
            wr_ack   <= 1'b0;
            ready    <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            validA <= 1'b0;
            validB <= 1'b0;
            wr_ack <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    // Requests during clearing are dropped and flagged.
                    if (readA || readB || write_Res) begin
                        drop_err <= 1'b1;
                    end
                    // Pointer stops at the last entry; the final zero write and the
                    // transition to READY share one edge.
                    if (clr_ptr == LAST_PTR) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + ADDRESS_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (readA) begin
                        data_opA <= rd_a_c;
                        validA   <= 1'b1;
                    end
                    if (readB) begin
                        data_opB <= rd_b_c;
                        validB   <= 1'b1;
                    end
                    wr_ack <= write_Res;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule : data_regfile

// File: tb/tb_data_regfile.sv
// Self-checking bench for data_regfile: directed vector table, hand-written
// reset/clear sequences and a randomized run against a behavioural model.
module tb_data_regfile;

    localparam int unsigned DW    = 10;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          readA, readB, write_Res;
    logic [AW-1:0] addr_opA, addr_opB, addr_Res;
    logic [DW-1:0] data_Res;
    logic [DW-1:0] data_opA, data_opB;
    logic          validA, validB, wr_ack, ready, drop_err;

    int errors = 0;
    int checks = 0;

    data_regfile #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn),
        .readA(readA), .readB(readB),
        .addr_opA(addr_opA), .addr_opB(addr_opB),
        .data_opA(data_opA), .data_opB(data_opB),
        .validA(validA), .validB(validB),
        .write_Res(write_Res), .addr_Res(addr_Res), .data_Res(data_Res),
        .wr_ack(wr_ack), .ready(ready), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ra;
        logic [AW-1:0] aa;
        logic          rb;
        logic [AW-1:0] ab;
        logic          ev_a;
        logic [DW-1:0] ed_a;
        logic          ev_b;
        logic [DW-1:0] ed_b;
        logic          e_ack;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        readA = 0; readB = 0; write_Res = 0;
        addr_opA = '0; addr_opB = '0; addr_Res = '0; data_Res = '0;
    endtask

    // Reset for one edge, then expect ready low for DEPTH-1 edges and high after the DEPTH-th.
    task automatic reset_and_clear(input string tag);
        rstn = 0;
        step();
        rstn = 1;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            step();
            chk({tag, "_ready_low"}, 32'(ready), 32'd0);
        end
        step();
        chk({tag, "_ready_high"}, 32'(ready), 32'd1);
    endtask

    // Read every entry on both ports (A ascending, B descending) and expect zero.
    task automatic read_all_zero(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            readA = 1; addr_opA = AW'(i);
            readB = 1; addr_opB = AW'(int'(DEPTH) - 1 - i);
            step();
            chk({tag, "_vA"}, 32'(validA), 32'd1);
            chk({tag, "_vB"}, 32'(validB), 32'd1);
            chk({tag, "_dA"}, 32'(data_opA), 32'd0);
            chk({tag, "_dB"}, 32'(data_opB), 32'd0);
        end
        idle();
    endtask

    // Behavioural model state for the randomized run.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clr_left;
    logic          m_drop;
    logic [DW-1:0] m_dA, m_dB;
    logic          m_vA, m_vB, m_ack;

    // Model one clock edge from the currently driven inputs.
    task automatic model_edge();
        logic [DW-1:0] oldA, oldB;
        m_vA = 0; m_vB = 0; m_ack = 0;
        if (!rstn) begin
            m_clr_left = DEPTH;
            m_drop = 0; m_dA = '0; m_dB = '0;
            foreach (m_mem[i]) m_mem[i] = '0;   // clearing guarantees zeros before any read
        end else if (m_clr_left > 0) begin
            if (readA || readB || write_Res) m_drop = 1;
            m_clr_left--;
        end else begin
            oldA = (BYP && write_Res && addr_opA == addr_Res) ? data_Res : m_mem[addr_opA];
            oldB = (BYP && write_Res && addr_opB == addr_Res) ? data_Res : m_mem[addr_opB];
            if (readA) begin m_dA = oldA; m_vA = 1; end
            if (readB) begin m_dB = oldB; m_vB = 1; end
            if (write_Res) begin m_mem[addr_Res] = data_Res; m_ack = 1; end
        end
    endtask

    initial begin
        rstn = 0;
        idle();

        // Reset state
        step();
        chk("rst_dA", 32'(data_opA), 32'd0);
        chk("rst_dB", 32'(data_opB), 32'd0);
        chk("rst_vA", 32'(validA), 32'd0);
        chk("rst_vB", 32'(validB), 32'd0);
        chk("rst_ack", 32'(wr_ack), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);

        // Power-up clear and zero read-back
        reset_and_clear("init");
        read_all_zero("init_zero");

        // Directed vector table; data ports hold 0 from the last zero read.
        //                 wr  wa     wd       ra  aa     rb  ab     evA edA                      evB edB      ack
        vecs[0]  = '{1'b1, 3'd3, 10'h155, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 10'h000,              1'b0, 10'h000, 1'b1};
        vecs[1]  = '{1'b0, 3'd0, 10'h000, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 10'h155,              1'b1, 10'h155, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 10'h000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 10'h155,              1'b0, 10'h155, 1'b0};
        vecs[3]  = '{1'b1, 3'd5, 10'h001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 10'h155,              1'b0, 10'h155, 1'b1};
        vecs[4]  = '{1'b1, 3'd5, 10'h0AA, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, BYP ? 10'h0AA : 10'h001, 1'b0, 10'h155, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 10'h000, 1'b1, 3'd5, 1'b1, 3'd3, 1'b1, 10'h0AA,              1'b1, 10'h155, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 10'h3FF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 10'h0AA,              1'b0, 10'h155, 1'b1};
        vecs[7]  = '{1'b1, 3'd7, 10'h200, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 10'h0AA,              1'b0, 10'h155, 1'b1};
        vecs[8]  = '{1'b1, 3'd1, 10'h011, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 10'h0AA,              1'b0, 10'h155, 1'b1};
        vecs[9]  = '{1'b0, 3'd0, 10'h000, 1'b1, 3'd0, 1'b1, 3'd7, 1'b1, 10'h3FF,              1'b1, 10'h200, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 10'h000, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 10'h011,              1'b0, 10'h200, 1'b0};
        vecs[11] = '{1'b1, 3'd1, 10'h022, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, BYP ? 10'h022 : 10'h011, 1'b1, BYP ? 10'h022 : 10'h011, 1'b1};
        vecs[12] = '{1'b0, 3'd0, 10'h000, 1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 10'h022,              1'b1, 10'h0AA, 1'b0};

        for (int v = 0; v < 13; v++) begin
            write_Res = vecs[v].wr; addr_Res = vecs[v].wa; data_Res = vecs[v].wd;
            readA = vecs[v].ra; addr_opA = vecs[v].aa;
            readB = vecs[v].rb; addr_opB = vecs[v].ab;
            step();
            chk($sformatf("vec%0d_vA", v), 32'(validA), 32'(vecs[v].ev_a));
            chk($sformatf("vec%0d_dA", v), 32'(data_opA), 32'(vecs[v].ed_a));
            chk($sformatf("vec%0d_vB", v), 32'(validB), 32'(vecs[v].ev_b));
            chk($sformatf("vec%0d_dB", v), 32'(data_opB), 32'(vecs[v].ed_b));
            chk($sformatf("vec%0d_ack", v), 32'(wr_ack), 32'(vecs[v].e_ack));
        end
        idle();
        step();
        chk("vec_end_ack_clear", 32'(wr_ack), 32'd0);
        chk("vec_end_drop", 32'(drop_err), 32'd0);

        // Write attempt during clear cycle 4 is dropped
        rstn = 0;
        step();
        rstn = 1;
        for (int c = 1; c <= int'(DEPTH); c++) begin
            if (c == 4) begin
                write_Res = 1; addr_Res = 3'd2; data_Res = 10'h3FF;
            end else if (c == 6) begin
                readA = 1; addr_opA = 3'd1;
            end else begin
                idle();
            end
            step();
            if (c == 4) begin
                chk("clr_wr_ack", 32'(wr_ack), 32'd0);
                chk("clr_wr_drop", 32'(drop_err), 32'd1);
            end
            if (c == 6) begin
                chk("clr_rd_vA", 32'(validA), 32'd0);
                chk("clr_rd_dA", 32'(data_opA), 32'd0);
            end
            chk("clr_ready", 32'(ready), (c == int'(DEPTH)) ? 32'd1 : 32'd0);
        end
        idle();
        readA = 1; addr_opA = 3'd2;
        step();
        chk("clr_addr2_vA", 32'(validA), 32'd1);
        chk("clr_addr2_dA", 32'(data_opA), 32'd0);
        chk("clr_drop_sticky", 32'(drop_err), 32'd1);
        idle();

        // Mid-operation reset with a read pending
        write_Res = 1; addr_Res = 3'd4; data_Res = 10'h123;
        step();
        idle();
        readA = 1; addr_opA = 3'd4;
        rstn = 0;
        step();
        chk("mid_rst_vA", 32'(validA), 32'd0);
        chk("mid_rst_dA", 32'(data_opA), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_drop", 32'(drop_err), 32'd0);
        idle();
        rstn = 1;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            step();
            chk("mid_rst_ready_low", 32'(ready), 32'd0);
        end
        step();
        chk("mid_rst_ready_high", 32'(ready), 32'd1);
        read_all_zero("mid_rst_zero");
        chk("mid_rst_drop_after", 32'(drop_err), 32'd0);

        // Randomized run against the behavioural model, starting from reset
        rstn = 0;
        model_edge();
        step();
        rstn = 1;
        for (int n = 0; n < 600; n++) begin
            rstn      = ($urandom_range(0, 79) != 0);
            readA     = $urandom_range(0, 1) == 1;
            readB     = $urandom_range(0, 1) == 1;
            write_Res = $urandom_range(0, 1) == 1;
            addr_opA  = AW'($urandom_range(0, DEPTH - 1));
            addr_opB  = ($urandom_range(0, 3) == 0) ? addr_opA : AW'($urandom_range(0, DEPTH - 1));
            addr_Res  = ($urandom_range(0, 2) == 0) ? addr_opA : AW'($urandom_range(0, DEPTH - 1));
            data_Res  = DW'($urandom);
            model_edge();
            step();
            chk("rnd_ready", 32'(ready), (m_clr_left == 0) ? 32'd1 : 32'd0);
            chk("rnd_drop", 32'(drop_err), 32'(m_drop));
            chk("rnd_vA", 32'(validA), 32'(m_vA));
            chk("rnd_vB", 32'(validB), 32'(m_vB));
            chk("rnd_ack", 32'(wr_ack), 32'(m_ack));
            chk("rnd_dA", 32'(data_opA), 32'(m_dA));
            chk("rnd_dB", 32'(data_opB), 32'(m_dB));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_data_regfile
